// File: rtl/halflife_pkg.sv
// Shared state encoding and default widths for the half-life decay timer.
package halflife_pkg;

  localparam int unsigned HL_WIDTH = 8;
  localparam int unsigned HL_PW    = 8;
  localparam int unsigned HL_HW    = 4;

  typedef enum logic [1:0] {
    HL_IDLE,
    HL_RUN,
    HL_DONE
  } hl_state_e;

endpackage

// File: rtl/halflife_tick_gen.sv
// Period counter: emits a one-cycle tick on the enabled cycle where the count is period-1.
module halflife_tick_gen
  import halflife_pkg::*;
#(
  parameter int unsigned PW = HL_PW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic [PW-1:0] i_period,
  output logic          o_tick
);

  logic [PW-1:0] r_cnt;
  logic          w_wrap;

  // i_period is never 0 here; the top maps 0 to 1 on load.
  assign w_wrap = (r_cnt == (i_period - {{(PW-1){1'b0}}, 1'b1}));
  assign o_tick = i_en && w_wrap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + {{(PW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/halflife_decay_timer.sv
// Exponential-decay timer: halves the activity every period cycles until it reaches the threshold.
// Optional HALFLIFE_THRESH_EN adds a thresh input; otherwise the threshold is 0.
module halflife_decay_timer
  import halflife_pkg::*;
#(
  parameter int unsigned WIDTH = HL_WIDTH,
  parameter int unsigned PW    = HL_PW,
  parameter int unsigned HW    = HL_HW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             start,
  input  logic             pause,
  input  logic [WIDTH-1:0] act_in,
  input  logic [PW-1:0]    period_in,
`ifdef HALFLIFE_THRESH_EN
  input  logic [WIDTH-1:0] thresh,
`endif
  output logic [WIDTH-1:0] act_out,
  output logic [HW-1:0]    halves_out,
  output logic             busy,
  output logic             done
);

  hl_state_e        r_state, w_state_nxt;
  logic [WIDTH-1:0] r_act, w_act_nxt;
  logic [PW-1:0]    r_period, w_period_nxt;
  logic [HW-1:0]    r_halves, w_halves_nxt;
  logic             r_done, w_done_nxt;
  logic             w_tick;
  logic [WIDTH-1:0] w_thresh;
  logic [WIDTH-1:0] w_half;

`ifdef HALFLIFE_THRESH_EN
  assign w_thresh = thresh;
`else
  assign w_thresh = '0;
`endif

  assign w_half = r_act >> 1;

  halflife_tick_gen #(
    .PW(PW)
  ) u_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (load || (r_state != HL_RUN)),
    .i_en    ((r_state == HL_RUN) && !pause),
    .i_period(r_period),
    .o_tick  (w_tick)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_act_nxt    = r_act;
    w_period_nxt = r_period;
    w_halves_nxt = r_halves;
    w_done_nxt   = 1'b0;
    if (load) begin
      w_state_nxt  = HL_IDLE;
      w_act_nxt    = act_in;
      w_period_nxt = (period_in == '0) ? {{(PW-1){1'b0}}, 1'b1} : period_in;
      w_halves_nxt = '0;
    end else begin
      case (r_state)
        HL_IDLE: begin
          if (start) begin
            if (r_act <= w_thresh) begin
              w_state_nxt = HL_DONE;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = HL_RUN;
            end
          end
        end
        HL_RUN: begin
          if (w_tick) begin
            w_act_nxt = w_half;
            if (r_halves != '1) w_halves_nxt = r_halves + {{(HW-1){1'b0}}, 1'b1};
            if (w_half <= w_thresh) begin
              w_state_nxt = HL_DONE;
              w_done_nxt  = 1'b1;
            end
          end
        end
        HL_DONE: ;
        default: w_state_nxt = HL_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= HL_IDLE;
      r_act    <= '0;
      r_period <= {{(PW-1){1'b0}}, 1'b1};
      r_halves <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_act    <= w_act_nxt;
      r_period <= w_period_nxt;
      r_halves <= w_halves_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign act_out    = r_act;
  assign halves_out = r_halves;
  assign busy       = (r_state == HL_RUN);
  assign done       = r_done;

endmodule

// File: tb/tb_halflife_decay_timer.sv
// Directed bench for halflife_decay_timer; define HALFLIFE_THRESH_EN to also cover the threshold.
module tb_halflife_decay_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       load, start, pause;
  logic [7:0] act_in;
  logic [7:0] period_in;
  logic [7:0] act_out;
  logic [3:0] halves_out;
  logic       busy, done;
`ifdef HALFLIFE_THRESH_EN
  logic [7:0] thresh;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  halflife_decay_timer dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .start     (start),
    .pause     (pause),
    .act_in    (act_in),
    .period_in (period_in),
`ifdef HALFLIFE_THRESH_EN
    .thresh    (thresh),
`endif
    .act_out   (act_out),
    .halves_out(halves_out),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] a, input logic [7:0] p);
    act_in    = a;
    period_in = p;
    load      = 1'b1;
    cyc(1);
    load      = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  int exp2[8] = '{100, 50, 25, 12, 6, 3, 1, 0};
  int exp3[5] = '{8, 4, 2, 1, 0};

  initial begin
    rst = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
    act_in = '0; period_in = '0;
`ifdef HALFLIFE_THRESH_EN
    thresh = '0;
`endif
    #1;
    check("rst_act", act_out, 0);
    check("rst_halves", halves_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    #10 rst = 1'b1;

    // A0=200, T=3
    do_load(8'd200, 8'd3);
    do_start();
    check("t2_busy", busy, 1);
    cyc(2);
    check("t2_latency_hold", act_out, 200);
    cyc(1);
    check("t2_first", act_out, exp2[0]);
    check("t2_halves1", halves_out, 1);
    for (int i = 1; i < 8; i++) begin
      cyc(3);
      check("t2_act", act_out, exp2[i]);
      if (i < 7) check("t2_nodone", done, 0);
    end
    check("t2_done", done, 1);
    check("t2_busy_drop", busy, 0);
    check("t2_halves8", halves_out, 8);
    cyc(1);
    check("t2_done_pulse", done, 0);

    // A0=16, T=0 treated as 1
    do_load(8'd16, 8'd0);
    do_start();
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      check("t3_act", act_out, exp3[i]);
      check("t3_done", done, (i == 4) ? 1 : 0);
    end
    cyc(1);
    check("t3_done_pulse", done, 0);

    // A0=64, T=4, pause for 10 edges mid-period
    do_load(8'd64, 8'd4);
    do_start();
    cyc(4);
    check("t4_first", act_out, 32);
    cyc(1);
    pause = 1'b1;
    cyc(10);
    check("t4_paused_act", act_out, 32);
    check("t4_paused_busy", busy, 1);
    pause = 1'b0;
    cyc(2);
    check("t4_pre_second", act_out, 32);
    check("t4_halves1", halves_out, 1);
    cyc(1);
    check("t4_second", act_out, 16);
    check("t4_halves2", halves_out, 2);
    cyc(16);
    check("t4_act1", act_out, 1);
    cyc(3);
    check("t4_act1_hold", act_out, 1);
    check("t4_nodone", done, 0);
    cyc(1);
    check("t4_zero", act_out, 0);
    check("t4_done", done, 1);
    check("t4_halves7", halves_out, 7);

    // load together with start from DONE: load wins
    act_in = 8'd5; period_in = 8'd2; load = 1'b1; start = 1'b1;
    cyc(1);
    load = 1'b0; start = 1'b0;
    check("t5_ld_act", act_out, 5);
    check("t5_ld_busy", busy, 0);
    check("t5_ld_done", done, 0);
    do_start();
    cyc(5);
    check("t5_act1", act_out, 1);
    // load on the completing-halving cycle
    act_in = 8'd9; period_in = 8'd3; load = 1'b1;
    cyc(1);
    load = 1'b0;
    check("t5_race_act", act_out, 9);
    check("t5_race_busy", busy, 0);
    check("t5_race_done", done, 0);
    check("t5_race_halves", halves_out, 0);
    cyc(1);
    check("t5_race_done2", done, 0);
    check("t5_race_act2", act_out, 9);
    // start with A0=0
    do_load(8'd0, 8'd1);
    do_start();
    check("t5_zero_done", done, 1);
    check("t5_zero_busy", busy, 0);
    cyc(1);
    check("t5_zero_pulse", done, 0);

    // asynchronous reset mid-RUN
    do_load(8'd200, 8'd3);
    do_start();
    cyc(3);
    check("t1_pre_act", act_out, 100);
    #2 rst = 1'b0;
    #1;
    check("t1_act", act_out, 0);
    check("t1_halves", halves_out, 0);
    check("t1_busy", busy, 0);
    check("t1_done", done, 0);
    #2 rst = 1'b1;
    cyc(1);
    check("t1_post_busy", busy, 0);
    check("t1_post_done", done, 0);

`ifdef HALFLIFE_THRESH_EN
    thresh = 8'd10;
    do_load(8'd100, 8'd2);
    do_start();
    cyc(2);
    check("t6_50", act_out, 50);
    cyc(2);
    check("t6_25", act_out, 25);
    cyc(2);
    check("t6_12", act_out, 12);
    check("t6_nodone", done, 0);
    cyc(2);
    check("t6_6", act_out, 6);
    check("t6_done", done, 1);
    check("t6_busy", busy, 0);
    cyc(3);
    check("t6_hold", act_out, 6);
    check("t6_pulse", done, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
